// File: rtl/io_pkg.sv
// Shared I/O address map for the multicycle RISC-V system.
// Each I/O register is selected by one address bit inside the window that
// has IO_BASE_bit set. The top-level read mux and io_input_port both use
// these constants, so the decode cannot drift between them.
package io_pkg;

    localparam int IO_LEDS_bit = 2;
    localparam int IO_HEX_bit  = 3;
    localparam int IO_KEY_bit  = 4;
    localparam int IO_SW_bit   = 5;
    localparam int IO_EDGE_bit = 6;
    localparam int IO_MASK_bit = 7;
    localparam int IO_BASE_bit = 8;

    // Register chosen for a read, after priority resolution.
    typedef enum logic [2:0] {
        RD_NONE = 3'd0,
        RD_KEY  = 3'd1,
        RD_SW   = 3'd2,
        RD_EDGE = 3'd3,
        RD_MASK = 3'd4
    } rd_sel_e;

    // Read decode. When several select bits are set, KEY > SW > EDGE > MASK.
    function automatic rd_sel_e decode_read(input logic [31:0] addr);
        rd_sel_e sel;
        if (!addr[IO_BASE_bit]) begin
            sel = RD_NONE;
        end else if (addr[IO_KEY_bit]) begin
            sel = RD_KEY;
        end else if (addr[IO_SW_bit]) begin
            sel = RD_SW;
        end else if (addr[IO_EDGE_bit]) begin
            sel = RD_EDGE;
        end else if (addr[IO_MASK_bit]) begin
            sel = RD_MASK;
        end else begin
            sel = RD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/io_input_port_if.sv
// CPU-side bus of the I/O input responder.
//   master: CPU (drives addr/memwrite/writedata, receives readdata/hit/irq)
//   slave : io_input_port
interface io_input_port_if;

    logic [31:0] addr;
    logic        memwrite;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hit;
    logic        irq;

    modport master (
        output addr, memwrite, writedata,
        input  readdata, hit, irq
    );

    modport slave (
        input  addr, memwrite, writedata,
        output readdata, hit, irq
    );

endinterface

// File: rtl/io_input_port_debounce.sv
// One-bit synchronizer + debouncer.
//   clk, reset_n : system clock, async active-low reset
//   pin          : raw asynchronous input
//   level        : accepted (debounced) level
//   flip         : high in the cycle whose closing edge flips 'level'
// RESET_VAL is the idle level of the pin; both synchronizer flops and the
// accepted state start there, so an idle pin causes no event after reset.
module io_input_port_debounce #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic flip
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          state_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= RESET_VAL;
            sync2_r <= RESET_VAL;
        end else begin
            sync1_r <= pin;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter and accepted state; any return to the accepted
    // level restarts the count, so short glitches never flip the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RESET_VAL;
            cnt_r   <= {CW{1'b0}};
        end else if (sync2_r == state_r) begin
            cnt_r   <= {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            state_r <= ~state_r;
            cnt_r   <= {CW{1'b0}};
        end else begin
            cnt_r   <= cnt_r + CW'(1);
        end
    end

    assign flip  = (sync2_r != state_r) && (cnt_r == CNT_LAST);
    assign level = state_r;

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped input responder for push-buttons and slide switches.
//   clk, reset_n : system clock, async active-low reset
//   key_pin      : raw buttons, active-low (pressed = 0)
//   sw_pin       : raw slide switches
//   bus          : CPU load/store bus (slave side): addr, memwrite,
//                  writedata in; readdata, hit, irq out
// Registers (in the addr[8] window): KEY 0x110 (ro), SW 0x120 (ro),
// EDGE 0x140 (sticky press events, write-1-to-clear), MASK 0x180 (rw).
// irq = |(EDGE & MASK). Reads are combinational from addr.
module io_input_port
    import io_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_pin,
    input  logic [N_SW-1:0]   sw_pin,
    io_input_port_if.slave    bus
);

    logic [N_KEYS-1:0] key_level_s;      // debounced pin level (1 = idle)
    logic [N_KEYS-1:0] key_flip_s;
    logic [N_KEYS-1:0] key_pressed_s;
    logic [N_KEYS-1:0] key_press_s;      // accepted 1->0 pin transition
    logic [N_SW-1:0]   sw_level_s;
    logic [N_SW-1:0]   sw_flip_unused_s; // switches raise no events
    logic [N_KEYS-1:0] edge_r;
    logic [N_KEYS-1:0] mask_r;
    logic [N_KEYS-1:0] edge_clr_s;
    logic              mask_we_s;
    logic [31:0]       readdata_s;
    rd_sel_e           rd_sel_s;
    logic [31:0]       addr_unused_s;    // only a few address bits decode
    logic [31:0]       wdata_unused_s;   // only the low N_KEYS bits are stored

    assign addr_unused_s  = bus.addr;
    assign wdata_unused_s = bus.writedata;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        io_input_port_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b1)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (key_pin[i]),
            .level   (key_level_s[i]),
            .flip    (key_flip_s[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        io_input_port_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b0)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (sw_pin[i]),
            .level   (sw_level_s[i]),
            .flip    (sw_flip_unused_s[i])
        );
    end

    assign key_pressed_s = ~key_level_s;
    // A flip while the level is still idle-high is a press being accepted,
    // so EDGE sets on the same edge as the KEY bit rises.
    assign key_press_s   = key_flip_s & key_level_s;

    // Store decode for EDGE clear and MASK write.
    always_comb begin
        if (bus.memwrite && bus.addr[IO_BASE_bit] && bus.addr[IO_EDGE_bit]) begin
            edge_clr_s = bus.writedata[N_KEYS-1:0];
        end else begin
            edge_clr_s = {N_KEYS{1'b0}};
        end
        if (bus.memwrite && bus.addr[IO_BASE_bit] && bus.addr[IO_MASK_bit]) begin
            mask_we_s = 1'b1;
        end else begin
            mask_we_s = 1'b0;
        end
    end

    // Sticky press events; a new press beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_r <= {N_KEYS{1'b0}};
        end else begin
            edge_r <= (edge_r & ~edge_clr_s) | key_press_s;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r <= {N_KEYS{1'b0}};
        end else if (mask_we_s) begin
            mask_r <= bus.writedata[N_KEYS-1:0];
        end else begin
            mask_r <= mask_r;
        end
    end

    // Combinational read mux; the CPU samples readdata in the same cycle.
    always_comb begin
        rd_sel_s = decode_read(bus.addr);
        case (rd_sel_s)
            RD_KEY:  readdata_s = 32'(key_pressed_s);
            RD_SW:   readdata_s = 32'(sw_level_s);
            RD_EDGE: readdata_s = 32'(edge_r);
            RD_MASK: readdata_s = 32'(mask_r);
            default: readdata_s = 32'h0000_0000;
        endcase
    end

    assign bus.readdata = readdata_s;
    assign bus.hit      = bus.addr[IO_BASE_bit] &
                          (bus.addr[IO_KEY_bit] | bus.addr[IO_SW_bit] |
                           bus.addr[IO_EDGE_bit] | bus.addr[IO_MASK_bit]);
    assign bus.irq      = |(edge_r & mask_r);

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port (N_KEYS=4, N_SW=10, DEBOUNCE_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_io_input_port;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_pin;
    logic [9:0] sw_pin;
    logic [31:0] rdata;
    int n_pass  = 0;
    int n_total = 0;

    io_input_port_if bus_if();

    io_input_port #(
        .N_KEYS          (4),
        .N_SW            (10),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .key_pin (key_pin),
        .sw_pin  (sw_pin),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.addr     = a;
        bus_if.memwrite = 1'b0;
        #1;
        d = bus_if.readdata;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr      = a;
        bus_if.writedata = d;
        bus_if.memwrite  = 1'b1;
        tick();
        bus_if.memwrite  = 1'b0;
    endtask

    task automatic test_reset();
        key_pin = 4'b1111;
        sw_pin  = 10'h3FF;
        reset_n = 1'b0;
        bus_if.addr = 32'h0; bus_if.writedata = 32'h0; bus_if.memwrite = 1'b0;
        repeat (3) tick();
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL reset_edge got=%h exp=%h", rdata, 32'h0); else n_pass++;
        rd(32'h180, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL reset_mask got=%h exp=%h", rdata, 32'h0); else n_pass++;
        n_total++; if (bus_if.irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", bus_if.irq); else n_pass++;
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            rd(32'h120, rdata);
            n_total++;
            if (rdata !== ((e < 6) ? 32'h0 : 32'h3FF))
                $display("FAIL reset_sw_edge%0d got=%h exp=%h", e, rdata, (e < 6) ? 32'h0 : 32'h3FF);
            else n_pass++;
            rd(32'h110, rdata);
            n_total++; if (rdata !== 32'h0) $display("FAIL reset_key_edge%0d got=%h exp=0", e, rdata); else n_pass++;
        end
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL reset_edge6 got=%h exp=0", rdata); else n_pass++;
        n_total++; if (bus_if.irq !== 1'b0) $display("FAIL reset_irq6 got=%b exp=0", bus_if.irq); else n_pass++;
    endtask

    task automatic test_press();
        tick();
        key_pin = 4'b1101;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) begin
                rd(32'h110, rdata);
                n_total++; if (rdata !== 32'h0) $display("FAIL press_key_edge5 got=%h exp=0", rdata); else n_pass++;
            end
        end
        rd(32'h110, rdata);
        n_total++; if (rdata !== 32'h2) $display("FAIL press_key_edge6 got=%h exp=2", rdata); else n_pass++;
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h2) $display("FAIL press_edge_edge6 got=%h exp=2", rdata); else n_pass++;
        repeat (4) tick();
        n_total++; if (bus_if.irq !== 1'b0) $display("FAIL press_irq_masked got=%b exp=0", bus_if.irq); else n_pass++;
        key_pin = 4'b1111;
        repeat (8) tick();
        rd(32'h110, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL release_key got=%h exp=0", rdata); else n_pass++;
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h2) $display("FAIL release_edge_kept got=%h exp=2", rdata); else n_pass++;
        store(32'h140, 32'h2);
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL press_edge_clear got=%h exp=0", rdata); else n_pass++;
    endtask

    task automatic test_switches();
        sw_pin = 10'h155;
        repeat (5) tick();
        rd(32'h120, rdata);
        n_total++; if (rdata !== 32'h3FF) $display("FAIL sw_edge5 got=%h exp=3ff", rdata); else n_pass++;
        tick();
        rd(32'h120, rdata);
        n_total++; if (rdata !== 32'h155) $display("FAIL sw_edge6 got=%h exp=155", rdata); else n_pass++;
    endtask

    task automatic test_glitch();
        key_pin = 4'b1011;
        repeat (3) tick();
        key_pin = 4'b1111;
        repeat (10) tick();
        rd(32'h110, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL glitch_key got=%h exp=0", rdata); else n_pass++;
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL glitch_edge got=%h exp=0", rdata); else n_pass++;
    endtask

    task automatic test_mask_irq();
        store(32'h180, 32'hF);
        rd(32'h180, rdata);
        n_total++; if (rdata !== 32'hF) $display("FAIL mask_read got=%h exp=f", rdata); else n_pass++;
        key_pin = 4'b1110;
        repeat (6) tick();
        n_total++; if (bus_if.irq !== 1'b1) $display("FAIL mask_irq_set got=%b exp=1", bus_if.irq); else n_pass++;
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h1) $display("FAIL mask_edge_set got=%h exp=1", rdata); else n_pass++;
        store(32'h140, 32'h1);
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL w1c_edge got=%h exp=0", rdata); else n_pass++;
        n_total++; if (bus_if.irq !== 1'b0) $display("FAIL w1c_irq got=%b exp=0", bus_if.irq); else n_pass++;
        key_pin = 4'b1111;
        repeat (8) tick();
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL release0_edge got=%h exp=0", rdata); else n_pass++;
    endtask

    task automatic test_set_wins();
        // Full latency after the earlier glitch shows its counter cleared.
        key_pin = 4'b1011;
        repeat (5) tick();
        rd(32'h110, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL setwins_key_edge5 got=%h exp=0", rdata); else n_pass++;
        store(32'h140, 32'h4);
        rd(32'h110, rdata);
        n_total++; if (rdata !== 32'h4) $display("FAIL setwins_key got=%h exp=4", rdata); else n_pass++;
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h4) $display("FAIL setwins_edge got=%h exp=4", rdata); else n_pass++;
        n_total++; if (bus_if.irq !== 1'b1) $display("FAIL setwins_irq got=%b exp=1", bus_if.irq); else n_pass++;
    endtask

    task automatic test_decode();
        // State: KEY=4, SW=0x155, EDGE=4, MASK=F.
        rd(32'h130, rdata);
        n_total++; if (rdata !== 32'h4) $display("FAIL dec_130 got=%h exp=4", rdata); else n_pass++;
        n_total++; if (bus_if.hit !== 1'b1) $display("FAIL dec_130_hit got=%b exp=1", bus_if.hit); else n_pass++;
        rd(32'h160, rdata);
        n_total++; if (rdata !== 32'h155) $display("FAIL dec_160 got=%h exp=155", rdata); else n_pass++;
        rd(32'h1C0, rdata);
        n_total++; if (rdata !== 32'h4) $display("FAIL dec_1c0 got=%h exp=4", rdata); else n_pass++;
        rd(32'h104, rdata);
        n_total++; if (rdata !== 32'h0) $display("FAIL dec_104 got=%h exp=0", rdata); else n_pass++;
        n_total++; if (bus_if.hit !== 1'b0) $display("FAIL dec_104_hit got=%b exp=0", bus_if.hit); else n_pass++;
        rd(32'h020, rdata);
        n_total++; if (bus_if.hit !== 1'b0) $display("FAIL dec_020_hit got=%b exp=0", bus_if.hit); else n_pass++;
        store(32'h110, 32'hFFFF_FFFF);
        rd(32'h110, rdata);
        n_total++; if (rdata !== 32'h4) $display("FAIL st_key_ignored got=%h exp=4", rdata); else n_pass++;
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h4) $display("FAIL st_key_edge got=%h exp=4", rdata); else n_pass++;
        store(32'h0C0, 32'h0);
        rd(32'h180, rdata);
        n_total++; if (rdata !== 32'hF) $display("FAIL st_nobase_mask got=%h exp=f", rdata); else n_pass++;
        store(32'h0C0, 32'hF);
        rd(32'h140, rdata);
        n_total++; if (rdata !== 32'h4) $display("FAIL st_nobase_edge got=%h exp=4", rdata); else n_pass++;
        store(32'h180, 32'h3);
        rd(32'h180, rdata);
        n_total++; if (rdata !== 32'h3) $display("FAIL mask_write3 got=%h exp=3", rdata); else n_pass++;
        n_total++; if (bus_if.irq !== 1'b0) $display("FAIL mask_irq_off got=%b exp=0", bus_if.irq); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_press();
        test_switches();
        test_glitch();
        test_mask_irq();
        test_set_wins();
        test_decode();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
